// File: rtl/ltl_report_collector.sv
// Timestamps cycles carrying property reports and buffers {match, ts} records in a FWFT FIFO.
// Also keeps sticky per-property flags, an overflow flag and a saturating drop counter.
module ltl_report_collector #(
    parameter int unsigned NUM_PROPS = 3,
    parameter int unsigned TS_W      = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DROP_W    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        clear,
    input  logic [NUM_PROPS-1:0]        match,
    output logic                        rpt_valid,
    input  logic                        rpt_ready,
    output logic [NUM_PROPS+TS_W-1:0]   rpt_data,
    output logic [NUM_PROPS-1:0]        sticky,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]      fifo_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned RecW = NUM_PROPS + TS_W;

    logic [TS_W-1:0]      ts_q, ts_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    logic [NUM_PROPS-1:0] sticky_q, sticky_d;
    logic                 overflow_q, overflow_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [RecW-1:0]      mem [DEPTH];

    logic cap, pop, full, push, drop;

    assign cap  = run & (|match);
    assign pop  = rpt_valid & rpt_ready;
    assign full = (level_q == LvlW'(DEPTH));
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    always_comb begin
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        sticky_d   = sticky_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            sticky_d   = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (run) begin
                ts_d = ts_q + TS_W'(1);
            end
            if (cap) begin
                sticky_d = sticky_q | match;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LvlW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LvlW'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sticky_q   <= sticky_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is not reset; empty entries are masked on the output instead.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_q] <= {match, ts_q};
        end
    end

    assign rpt_valid  = (level_q != '0);
    assign rpt_data   = rpt_valid ? mem[rd_ptr_q] : '0;
    assign sticky     = sticky_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed bench for ltl_report_collector: default instance plus a TS_W=4 instance for wrap.
module tb_ltl_report_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        run, clear, rpt_ready;
    logic [2:0]  match;
    logic        rpt_valid;
    logic [18:0] rpt_data;
    logic [2:0]  sticky;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [3:0]  fifo_level;

    logic        run4, clear4, ready4;
    logic [2:0]  match4;
    logic        valid4;
    logic [6:0]  data4;
    logic [2:0]  sticky4;
    logic        ovf4;
    logic [7:0]  drop4;
    logic [3:0]  lvl4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ltl_report_collector dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .match      (match),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_data   (rpt_data),
        .sticky     (sticky),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    ltl_report_collector #(.TS_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .run        (run4),
        .clear      (clear4),
        .match      (match4),
        .rpt_valid  (valid4),
        .rpt_ready  (ready4),
        .rpt_data   (data4),
        .sticky     (sticky4),
        .overflow   (ovf4),
        .drop_cnt   (drop4),
        .fifo_level (lvl4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [18:0] exp_rec;
        reset = 1'b0; run = 1'b0; clear = 1'b0; rpt_ready = 1'b0; match = '0;
        run4 = 1'b0; clear4 = 1'b0; ready4 = 1'b0; match4 = '0;
        #1;
        check("rst_valid", 32'(rpt_valid), 0);
        check("rst_data", 32'(rpt_data), 0);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        check("rst_level", 32'(fifo_level), 0);
        check("rst_sticky", 32'(sticky), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_valid_post", 32'(rpt_valid), 0);
        check("rst_data_post", 32'(rpt_data), 0);

        // T1: single report at ts=3
        run = 1'b1;
        repeat (3) cycle();
        check("t1_pre_level", 32'(fifo_level), 0);
        match = 3'b010;
        cycle();
        match = '0;
        check("t1_valid", 32'(rpt_valid), 1);
        check("t1_data", 32'(rpt_data), 32'({3'b010, 16'd3}));
        repeat (2) cycle();
        run = 1'b0;
        check("t1_level", 32'(fifo_level), 1);
        check("t1_sticky", 32'(sticky), 3'b010);
        rpt_ready = 1'b1;
        cycle();
        rpt_ready = 1'b0;
        check("t1_popped", 32'(rpt_valid), 0);

        // T2: match without run is ignored and ts holds at 6
        match = 3'b101;
        repeat (2) cycle();
        check("t2_level", 32'(fifo_level), 0);
        check("t2_sticky", 32'(sticky), 3'b010);
        run = 1'b1; match = 3'b001;
        cycle();
        run = 1'b0; match = '0;
        check("t2_ts_hold", 32'(rpt_data), 32'({3'b001, 16'd6}));
        check("t2_sticky2", 32'(sticky), 3'b011);
        rpt_ready = 1'b1;
        cycle();
        rpt_ready = 1'b0;

        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clr_sticky", 32'(sticky), 0);
        check("clr_level", 32'(fifo_level), 0);

        // T3: 10 captures into 8 entries
        run = 1'b1; match = 3'b100;
        repeat (10) cycle();
        run = 1'b0; match = '0;
        check("t3_level", 32'(fifo_level), 8);
        check("t3_ovf", 32'(overflow), 1);
        check("t3_drop", 32'(drop_cnt), 2);
        check("t3_sticky", 32'(sticky), 3'b100);
        check("t3_head", 32'(rpt_data), 32'({3'b100, 16'd0}));
        cycle();
        check("t3_head_stable", 32'(rpt_data), 32'({3'b100, 16'd0}));

        // T4: full with cap and pop together; new record has ts=10
        run = 1'b1; match = 3'b110; rpt_ready = 1'b1;
        cycle();
        run = 1'b0; match = '0;
        check("t4_level", 32'(fifo_level), 8);
        check("t4_drop", 32'(drop_cnt), 2);
        for (int k = 1; k < 8; k++) begin
            exp_rec = {3'b100, 16'(k)};
            check($sformatf("t3_drain%0d", k), 32'(rpt_data), 32'(exp_rec));
            cycle();
        end
        check("t4_last", 32'(rpt_data), 32'({3'b110, 16'd10}));
        cycle();
        rpt_ready = 1'b0;
        check("t4_empty_valid", 32'(rpt_valid), 0);
        check("t4_empty_level", 32'(fifo_level), 0);

        // T5: 4-bit timestamp wraps after 16 symbols
        run4 = 1'b1; match4 = 3'b001;
        cycle();
        match4 = '0;
        repeat (15) cycle();
        match4 = 3'b010;
        cycle();
        run4 = 1'b0; match4 = '0;
        check("t5_level", 32'(lvl4), 2);
        check("t5_first", 32'(data4), 32'({3'b001, 4'd0}));
        ready4 = 1'b1;
        cycle();
        ready4 = 1'b0;
        check("t5_wrap", 32'(data4), 32'({3'b010, 4'd0}));

        // T6: clear with coincident capture, then async reset mid-stream
        run = 1'b1; match = 3'b001;
        repeat (3) cycle();
        check("t6_level3", 32'(fifo_level), 3);
        clear = 1'b1; match = 3'b111;
        cycle();
        clear = 1'b0; run = 1'b0; match = '0;
        check("t6_level", 32'(fifo_level), 0);
        check("t6_valid", 32'(rpt_valid), 0);
        check("t6_drop", 32'(drop_cnt), 0);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_sticky", 32'(sticky), 0);
        run = 1'b1; match = 3'b011;
        repeat (2) cycle();
        check("t6_refill", 32'(fifo_level), 2);
        #3;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rpt_valid), 0);
        check("t6_rst_data", 32'(rpt_data), 0);
        check("t6_rst_level", 32'(fifo_level), 0);
        check("t6_rst_sticky", 32'(sticky), 0);
        check("t6_rst_valid4", 32'(valid4), 0);
        run = 1'b0; match = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
